tcm_mem_pipe: RTL and testbench
===============================

TCM_MEM_PIPE -- requirements
Module: tcm_mem_pipe

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, byte-address width; memory size is 2^ADDR_W bytes (ADDR_W 12..20).
REQ-002 SHALL have parameter I_LAT, default 1, instruction-fetch response latency in cycles (1..4).
REQ-003 SHALL have parameter D_LAT, default 1, data response latency in cycles (1..4).
REQ-004 SHALL have parameter TAG_W, default 11, request/response tag width.
REQ-005 SHALL have ports: clk_i in 1 clock; rst_i in 1 reset, synchronous, active-high.
REQ-006 SHALL have fetch ports: mem_i_rd_i in 1 fetch request; mem_i_flush_i in 1; mem_i_invalidate_i in 1; mem_i_pc_i in 32 fetch address; mem_i_accept_o out 1; mem_i_valid_o out 1; mem_i_error_o out 1; mem_i_inst_o out 32.
REQ-007 SHALL have data ports: mem_d_addr_i in 32; mem_d_data_wr_i in 32; mem_d_rd_i in 1; mem_d_wr_i in 4 byte strobes; mem_d_cacheable_i in 1; mem_d_req_tag_i in TAG_W; mem_d_invalidate_i, mem_d_writeback_i, mem_d_flush_i in 1 each; mem_d_accept_o out 1; mem_d_ack_o out 1; mem_d_error_o out 1; mem_d_data_rd_o out 32; mem_d_resp_tag_o out TAG_W.
REQ-008 SHALL have backdoor load ports: bd_wr_i in 1 byte write enable; bd_addr_i in ADDR_W byte address; bd_data_i in 8 byte data.

Function
REQ-009 Storage SHALL be little-endian bytes; fetch and data ports SHALL ignore address bits [1:0].
REQ-010 mem_i_accept_o and mem_d_accept_o SHALL be 1 every cycle outside reset; one request per port per cycle.
REQ-011 Fetch with mem_i_rd_i=1 at cycle N SHALL assert mem_i_valid_o for exactly one cycle at N+I_LAT with the word read at cycle N.
REQ-012 Back-to-back fetches SHALL pipeline fully: one response per cycle, in order, no bubbles.
REQ-013 mem_i_flush_i or mem_i_invalidate_i SHALL be accepted, produce no response and not alter memory or in-flight fetches.
REQ-014 Data read (mem_d_rd_i=1, mem_d_wr_i=0) at cycle N SHALL assert mem_d_ack_o at N+D_LAT with the read word and the captured tag.
REQ-015 Data write (mem_d_wr_i!=0) SHALL update only strobed bytes at the accepting clock edge and ack at N+D_LAT with tag and mem_d_data_rd_o=0.
REQ-016 mem_d_rd_i=1 with mem_d_wr_i!=0 in one cycle SHALL be treated as a write.
REQ-017 Data flush, invalidate or writeback request SHALL ack at N+D_LAT with its tag and no memory effect; if combined with rd/wr, one ack SHALL result.
REQ-018 Reads on either port in the cycle of a write to the same word SHALL return pre-write data; reads in any later cycle SHALL see written data.
REQ-019 Backdoor write SHALL update one byte at the clock edge; on same-cycle collision with a data-port write to that byte, backdoor data SHALL win.
REQ-020 Latency pipelines SHALL be shift registers of depth I_LAT / D_LAT carrying valid, data, tag, error.
REQ-021 cacheable_i SHALL be ignored.

Reset
REQ-022 While rst_i=1: all valid/ack/error outputs 0, inst/data_rd/resp_tag 0, accepts 0; all pipeline stages cleared.
REQ-023 Reset asserted mid-operation SHALL discard every in-flight response; none SHALL appear after reset deasserts.
REQ-024 Memory contents SHALL NOT be cleared by reset; backdoor writes SHALL function during reset.

Configuration
REQ-025 With TCM_MEM_RANGE_ERR_EN defined: an address with any bit [31:ADDR_W] set SHALL return error=1 with its response, data 0, write suppressed.
REQ-026 Without TCM_MEM_RANGE_ERR_EN: addresses SHALL wrap modulo 2^ADDR_W and both error outputs SHALL be constant 0.

Verification
REQ-027 Backdoor-load 0x00000013 at 0x0, I_LAT=3, fetch pc 0x0 at cycle 10 -> mem_i_valid_o=1 at cycle 13 only, inst 0x00000013.
REQ-028 Write 0xAABBCCDD strobe 4'b0101 to 0x100 over 0x11223344, then read tag 0x2A -> ack with data 0x11BB33DD, tag 0x2A.
REQ-029 Fetches at pc 0x0,0x4,0x8 on consecutive cycles, I_LAT=2 -> three consecutive valids in order, no gaps.
REQ-030 Same-cycle write 0xFFFFFFFF to 0x200 and fetch 0x200 (old 0x0) -> fetch returns 0x0; fetch next cycle returns 0xFFFFFFFF.
REQ-031 Read issued, rst_i pulsed one cycle before its ack, D_LAT=2 -> no ack during or after reset.
REQ-032 ADDR_W=16, read 0x00010000: with TCM_MEM_RANGE_ERR_EN -> ack, error=1, data 0; without -> ack, error=0, data of 0x0000.

Source files
------------

// File: rtl/tcm_mem_pipe.sv
// rtl/tcm_mem_pipe.sv - tightly coupled memory with fixed-latency fetch and data response pipelines
// Optional build macro TCM_MEM_RANGE_ERR_EN: flag out-of-range addresses instead of wrapping.
module tcm_mem_pipe #(
  parameter int ADDR_W = 16,
  parameter int I_LAT  = 1,
  parameter int D_LAT  = 1,
  parameter int TAG_W  = 11
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mem_i_rd_i,
  input  logic              mem_i_flush_i,
  input  logic              mem_i_invalidate_i,
  input  logic [31:0]       mem_i_pc_i,
  output logic              mem_i_accept_o,
  output logic              mem_i_valid_o,
  output logic              mem_i_error_o,
  output logic [31:0]       mem_i_inst_o,
  input  logic [31:0]       mem_d_addr_i,
  input  logic [31:0]       mem_d_data_wr_i,
  input  logic              mem_d_rd_i,
  input  logic [3:0]        mem_d_wr_i,
  input  logic              mem_d_cacheable_i,
  input  logic [TAG_W-1:0]  mem_d_req_tag_i,
  input  logic              mem_d_invalidate_i,
  input  logic              mem_d_writeback_i,
  input  logic              mem_d_flush_i,
  output logic              mem_d_accept_o,
  output logic              mem_d_ack_o,
  output logic              mem_d_error_o,
  output logic [31:0]       mem_d_data_rd_o,
  output logic [TAG_W-1:0]  mem_d_resp_tag_o,
  input  logic              bd_wr_i,
  input  logic [ADDR_W-1:0] bd_addr_i,
  input  logic [7:0]        bd_data_i
);

  localparam int WIDX  = ADDR_W - 2;
  localparam int WORDS = 2 ** WIDX;

  logic [31:0] mem_q [WORDS];

  logic [WIDX-1:0] i_idx, d_idx, bd_idx;
  logic            i_err, d_err;
  logic            i_req, d_req, d_wr, d_wr_en;
  logic [31:0]     i_word, d_word;
  logic            unused_bits;

  assign i_idx  = mem_i_pc_i[ADDR_W-1:2];
  assign d_idx  = mem_d_addr_i[ADDR_W-1:2];
  assign bd_idx = bd_addr_i[ADDR_W-1:2];
  assign d_wr   = |mem_d_wr_i;

`ifdef TCM_MEM_RANGE_ERR_EN
  assign i_err = |mem_i_pc_i[31:ADDR_W];
  assign d_err = (|mem_d_addr_i[31:ADDR_W]) & (mem_d_rd_i | d_wr);
`else
  assign i_err = 1'b0;
  assign d_err = 1'b0;
`endif

  // Flush/invalidate on the fetch side are accepted but never generate a response.
  assign unused_bits = ^{mem_d_cacheable_i, mem_i_flush_i, mem_i_invalidate_i,
                         mem_i_pc_i[1:0], mem_d_addr_i[1:0], bd_addr_i[1:0],
                         mem_i_pc_i[31:ADDR_W], mem_d_addr_i[31:ADDR_W]};

  assign i_req   = mem_i_rd_i & ~rst_i;
  assign d_req   = ~rst_i & (mem_d_rd_i | d_wr | mem_d_flush_i | mem_d_invalidate_i | mem_d_writeback_i);
  assign d_wr_en = d_wr & ~rst_i & ~d_err;

  assign i_word = i_err ? 32'h0 : mem_q[i_idx];
  assign d_word = (d_err | d_wr | ~mem_d_rd_i) ? 32'h0 : mem_q[d_idx];

  // Backdoor store is issued last so it wins a same-byte collision with the data port.
  always_ff @(posedge clk_i) begin
    if (d_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_d_wr_i[b]) mem_q[d_idx][8*b +: 8] <= mem_d_data_wr_i[8*b +: 8];
      end
    end
    if (bd_wr_i) mem_q[bd_idx][{bd_addr_i[1:0], 3'b000} +: 8] <= bd_data_i;
  end

  logic [I_LAT-1:0] i_vld_q, i_vld_d, i_err_q, i_err_d;
  logic [31:0]      i_dat_q [I_LAT];
  logic [31:0]      i_dat_d [I_LAT];

  always_comb begin
    i_vld_d    = '0;
    i_err_d    = '0;
    i_dat_d    = i_dat_q;
    i_vld_d[0] = i_req;
    i_err_d[0] = i_req & i_err;
    i_dat_d[0] = i_req ? i_word : 32'h0;
    for (int s = 1; s < I_LAT; s++) begin
      i_vld_d[s] = i_vld_q[s-1];
      i_err_d[s] = i_err_q[s-1];
      i_dat_d[s] = i_dat_q[s-1];
    end
  end

  logic [D_LAT-1:0] d_vld_q, d_vld_d, d_err_q, d_err_d;
  logic [31:0]      d_dat_q [D_LAT];
  logic [31:0]      d_dat_d [D_LAT];
  logic [TAG_W-1:0] d_tag_q [D_LAT];
  logic [TAG_W-1:0] d_tag_d [D_LAT];

  always_comb begin
    d_vld_d    = '0;
    d_err_d    = '0;
    d_dat_d    = d_dat_q;
    d_tag_d    = d_tag_q;
    d_vld_d[0] = d_req;
    d_err_d[0] = d_req & d_err;
    d_dat_d[0] = d_req ? d_word : 32'h0;
    d_tag_d[0] = d_req ? mem_d_req_tag_i : '0;
    for (int s = 1; s < D_LAT; s++) begin
      d_vld_d[s] = d_vld_q[s-1];
      d_err_d[s] = d_err_q[s-1];
      d_dat_d[s] = d_dat_q[s-1];
      d_tag_d[s] = d_tag_q[s-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      i_vld_q <= '0;
      i_err_q <= '0;
      d_vld_q <= '0;
      d_err_q <= '0;
      for (int s = 0; s < I_LAT; s++) i_dat_q[s] <= '0;
      for (int s = 0; s < D_LAT; s++) begin
        d_dat_q[s] <= '0;
        d_tag_q[s] <= '0;
      end
    end else begin
      i_vld_q <= i_vld_d;
      i_err_q <= i_err_d;
      i_dat_q <= i_dat_d;
      d_vld_q <= d_vld_d;
      d_err_q <= d_err_d;
      d_dat_q <= d_dat_d;
      d_tag_q <= d_tag_d;
    end
  end

  // Outputs are gated so they read zero from the first cycle reset is high.
  assign mem_i_accept_o   = ~rst_i;
  assign mem_d_accept_o   = ~rst_i;
  assign mem_i_valid_o    = i_vld_q[I_LAT-1] & ~rst_i;
  assign mem_i_error_o    = i_err_q[I_LAT-1] & ~rst_i;
  assign mem_i_inst_o     = i_dat_q[I_LAT-1] & {32{~rst_i}};
  assign mem_d_ack_o      = d_vld_q[D_LAT-1] & ~rst_i;
  assign mem_d_error_o    = d_err_q[D_LAT-1] & ~rst_i;
  assign mem_d_data_rd_o  = d_dat_q[D_LAT-1] & {32{~rst_i}};
  assign mem_d_resp_tag_o = d_tag_q[D_LAT-1] & {TAG_W{~rst_i}};

endmodule

// File: tb/tb_tcm_mem_pipe.sv
// tb/tb_tcm_mem_pipe.sv - directed self-checking bench for tcm_mem_pipe
// Instance a: I_LAT=2, D_LAT=2; instance b: I_LAT=3, D_LAT=1; both share every input.
module tb_tcm_mem_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_rd, i_flush, i_inv;
  logic [31:0] i_pc;
  logic [31:0] d_addr, d_wdata;
  logic        d_rd;
  logic [3:0]  d_wr;
  logic        d_cache;
  logic [10:0] d_tag;
  logic        d_inv, d_wb, d_flush;
  logic        bd_wr;
  logic [15:0] bd_addr;
  logic [7:0]  bd_data;

  logic        a_i_acc, a_i_vld, a_i_err, a_d_acc, a_d_ack, a_d_err;
  logic [31:0] a_i_inst, a_d_data;
  logic [10:0] a_d_tag;
  logic        b_i_acc, b_i_vld, b_i_err, b_d_acc, b_d_ack, b_d_err;
  logic [31:0] b_i_inst, b_d_data;
  logic [10:0] b_d_tag;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tcm_mem_pipe #(.ADDR_W(16), .I_LAT(2), .D_LAT(2), .TAG_W(11)) dut_a (
    .clk_i(clk), .rst_i(rst),
    .mem_i_rd_i(i_rd), .mem_i_flush_i(i_flush), .mem_i_invalidate_i(i_inv), .mem_i_pc_i(i_pc),
    .mem_i_accept_o(a_i_acc), .mem_i_valid_o(a_i_vld), .mem_i_error_o(a_i_err), .mem_i_inst_o(a_i_inst),
    .mem_d_addr_i(d_addr), .mem_d_data_wr_i(d_wdata), .mem_d_rd_i(d_rd), .mem_d_wr_i(d_wr),
    .mem_d_cacheable_i(d_cache), .mem_d_req_tag_i(d_tag), .mem_d_invalidate_i(d_inv),
    .mem_d_writeback_i(d_wb), .mem_d_flush_i(d_flush),
    .mem_d_accept_o(a_d_acc), .mem_d_ack_o(a_d_ack), .mem_d_error_o(a_d_err),
    .mem_d_data_rd_o(a_d_data), .mem_d_resp_tag_o(a_d_tag),
    .bd_wr_i(bd_wr), .bd_addr_i(bd_addr), .bd_data_i(bd_data)
  );

  tcm_mem_pipe #(.ADDR_W(16), .I_LAT(3), .D_LAT(1), .TAG_W(11)) dut_b (
    .clk_i(clk), .rst_i(rst),
    .mem_i_rd_i(i_rd), .mem_i_flush_i(i_flush), .mem_i_invalidate_i(i_inv), .mem_i_pc_i(i_pc),
    .mem_i_accept_o(b_i_acc), .mem_i_valid_o(b_i_vld), .mem_i_error_o(b_i_err), .mem_i_inst_o(b_i_inst),
    .mem_d_addr_i(d_addr), .mem_d_data_wr_i(d_wdata), .mem_d_rd_i(d_rd), .mem_d_wr_i(d_wr),
    .mem_d_cacheable_i(d_cache), .mem_d_req_tag_i(d_tag), .mem_d_invalidate_i(d_inv),
    .mem_d_writeback_i(d_wb), .mem_d_flush_i(d_flush),
    .mem_d_accept_o(b_d_acc), .mem_d_ack_o(b_d_ack), .mem_d_error_o(b_d_err),
    .mem_d_data_rd_o(b_d_data), .mem_d_resp_tag_o(b_d_tag),
    .bd_wr_i(bd_wr), .bd_addr_i(bd_addr), .bd_data_i(bd_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    i_rd = 0; i_flush = 0; i_inv = 0; i_pc = 0;
    d_addr = 0; d_wdata = 0; d_rd = 0; d_wr = 0; d_cache = 0; d_tag = 0;
    d_inv = 0; d_wb = 0; d_flush = 0;
    bd_wr = 0; bd_addr = 0; bd_data = 0;
  endtask

  task automatic bd_word(input logic [15:0] addr, input logic [31:0] word);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      bd_wr = 1; bd_addr = addr + 16'(b); bd_data = word[8*b +: 8];
    end
    @(negedge clk);
    bd_wr = 0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_i_valid"}, 32'(a_i_vld), 32'h0);
    chk({tag, "_d_ack"},   32'(a_d_ack), 32'h0);
    chk({tag, "_inst"},    a_i_inst,     32'h0);
    chk({tag, "_data"},    a_d_data,     32'h0);
    chk({tag, "_tag"},     32'(a_d_tag), 32'h0);
    chk({tag, "_errs"},    32'({a_i_err, a_d_err}), 32'h0);
  endtask

  initial begin
    idle();
    rst = 1;
    // Requests during reset must be refused and never answered.
    @(negedge clk);
    i_rd = 1; d_rd = 1; d_tag = 11'h1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_i_accept", 32'(a_i_acc), 32'h0);
    chk("rst_d_accept", 32'(a_d_acc), 32'h0);
    chk_quiet("rst");
    idle();
    // Memory is loaded through the backdoor while still in reset.
    bd_word(16'h0000, 32'h0000_0013);
    bd_word(16'h0004, 32'hDEAD_BEEF);
    bd_word(16'h0008, 32'h1234_5678);
    bd_word(16'h0100, 32'h1122_3344);
    bd_word(16'h0200, 32'h0000_0000);
    @(negedge clk);
    rst = 0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("post_rst_quiet_valid", 32'(a_i_vld | b_i_vld), 32'h0);
      chk("post_rst_quiet_ack",   32'(a_d_ack | b_d_ack), 32'h0);
    end
    chk("i_accept", 32'(a_i_acc), 32'h1);
    chk("d_accept", 32'(a_d_acc), 32'h1);

    // Single fetch of pc 0: a answers 2 cycles later, b 3 cycles later, each for one cycle.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k > 0) begin
        chk("fetch1_a_valid", 32'(a_i_vld), 32'(k == 2));
        chk("fetch1_b_valid", 32'(b_i_vld), 32'(k == 3));
        if (k == 2) chk("fetch1_a_inst", a_i_inst, 32'h0000_0013);
        if (k == 3) chk("fetch1_b_inst", b_i_inst, 32'h0000_0013);
      end
      idle();
      if (k == 0) begin i_rd = 1; i_pc = 32'h0; end
    end

    // Strobed write, read-back, then a flush-only request.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 1) chk("wr_b_ack", 32'(b_d_ack), 32'h1);
      if (k == 1) chk("wr_a_ack_early", 32'(a_d_ack), 32'h0);
      if (k == 2) begin
        chk("wr_ack", 32'(a_d_ack), 32'h1);
        chk("wr_tag", 32'(a_d_tag), 32'h11);
        chk("wr_data", a_d_data, 32'h0);
      end
      if (k == 3) chk("wr_ack_once", 32'(a_d_ack), 32'h0);
      if (k == 5) begin
        chk("rd_ack", 32'(a_d_ack), 32'h1);
        chk("rd_tag", 32'(a_d_tag), 32'h2A);
        chk("rd_data", a_d_data, 32'h11BB_33DD);
      end
      if (k == 8) begin
        chk("flush_ack", 32'(a_d_ack), 32'h1);
        chk("flush_tag", 32'(a_d_tag), 32'h7);
        chk("flush_data", a_d_data, 32'h0);
      end
      if (k == 9) chk("flush_ack_once", 32'(a_d_ack), 32'h0);
      idle();
      if (k == 0) begin d_addr = 32'h100; d_wdata = 32'hAABB_CCDD; d_wr = 4'b0101; d_tag = 11'h11; end
      if (k == 3) begin d_addr = 32'h101; d_rd = 1; d_tag = 11'h2A; end
      if (k == 6) begin d_addr = 32'h100; d_flush = 1; d_tag = 11'h7; end
    end

    // Back-to-back fetches 0,4,8 with I_LAT=2: three consecutive valids in order.
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk("pipe_valid", 32'(a_i_vld), 32'(k >= 2 && k <= 4));
      if (k == 2) chk("pipe_inst0", a_i_inst, 32'h0000_0013);
      if (k == 3) chk("pipe_inst1", a_i_inst, 32'hDEAD_BEEF);
      if (k == 4) chk("pipe_inst2", a_i_inst, 32'h1234_5678);
      idle();
      if (k < 3) begin i_rd = 1; i_pc = 32'(4 * k); end
    end

    // Same-cycle write/fetch sees old data; a fetch flush/invalidate gives no response.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 2) begin
        chk("wf_same_valid", 32'(a_i_vld), 32'h1);
        chk("wf_same_inst", a_i_inst, 32'h0);
      end
      if (k == 3) begin
        chk("wf_next_valid", 32'(a_i_vld), 32'h1);
        chk("wf_next_inst", a_i_inst, 32'hFFFF_FFFF);
      end
      if (k == 4) chk("iflush_no_valid", 32'(a_i_vld), 32'h0);
      idle();
      if (k == 0) begin
        d_addr = 32'h200; d_wdata = 32'hFFFF_FFFF; d_wr = 4'hF;
        i_rd = 1; i_pc = 32'h200;
      end
      if (k == 1) begin i_rd = 1; i_pc = 32'h202; end
      if (k == 2) begin i_flush = 1; i_inv = 1; end
    end

    // Backdoor byte wins over a data-port write to the same byte.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 3) begin
        chk("bd_win_ack", 32'(a_d_ack), 32'h1);
        chk("bd_win_data", a_d_data, 32'h0000_5A00);
      end
      idle();
      if (k == 0) begin
        d_addr = 32'h8; d_wdata = 32'h0; d_wr = 4'hF;
        bd_wr = 1; bd_addr = 16'h0009; bd_data = 8'h5A;
      end
      if (k == 1) begin d_addr = 32'h8; d_rd = 1; d_tag = 11'h3; end
    end

    // Reset pulsed one cycle before the read's ack discards it.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k >= 2) chk("rst_flight_ack", 32'(a_d_ack), 32'h0);
      if (k == 2) chk("rst_pulse_accept", 32'(a_d_acc), 32'h0);
      if (k == 3) chk("rst_done_accept", 32'(a_d_acc), 32'h1);
      idle();
      if (k == 0) begin d_addr = 32'h100; d_rd = 1; d_tag = 11'h5; end
      if (k == 1) rst = 1;
      if (k == 2) rst = 0;
    end

    // Out-of-range address: wraps to 0x0000 by default, errors when range checking is built in.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 2) begin
        chk("oor_ack", 32'(a_d_ack), 32'h1);
        chk("oor_tag", 32'(a_d_tag), 32'h33);
        chk("oor_i_valid", 32'(a_i_vld), 32'h1);
`ifdef TCM_MEM_RANGE_ERR_EN
        chk("oor_d_err", 32'(a_d_err), 32'h1);
        chk("oor_d_data", a_d_data, 32'h0);
        chk("oor_i_err", 32'(a_i_err), 32'h1);
        chk("oor_i_inst", a_i_inst, 32'h0);
`else
        chk("oor_d_err", 32'(a_d_err), 32'h0);
        chk("oor_d_data", a_d_data, 32'h0000_0013);
        chk("oor_i_err", 32'(a_i_err), 32'h0);
        chk("oor_i_inst", a_i_inst, 32'h0000_0013);
`endif
      end
      idle();
      if (k == 0) begin
        d_addr = 32'h0001_0000; d_rd = 1; d_tag = 11'h33; d_cache = 1;
        i_rd = 1; i_pc = 32'h0001_0000;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
